// File: rtl/spm_program_loader_if.sv
// Bundles the byte-stream input and the SPM external-write/status outputs
// of the program loader. The loader takes the slave side; the stream source
// and SPM/core side take the master side.
interface spm_program_loader_if #(
  parameter int WORD_SIZE = 8
);
  // byte stream from the host
  logic [WORD_SIZE-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 reload;

  // SPM external write port
  logic                 ext_write;
  logic [WORD_SIZE-1:0] address_bus;
  logic [WORD_SIZE-1:0] data_bus;

  // core control and status
  logic                 cpu_rst_n;
  logic                 busy;
  logic                 err;

  modport master (
    output in_data,
    output in_valid,
    output reload,
    input  in_ready,
    input  ext_write,
    input  address_bus,
    input  data_bus,
    input  cpu_rst_n,
    input  busy,
    input  err
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  reload,
    output in_ready,
    output ext_write,
    output address_bus,
    output data_bus,
    output cpu_rst_n,
    output busy,
    output err
  );
endinterface

// File: rtl/spm_program_loader.sv
// Program loader for the RISC SPM core. Parses a framed image
// (LEN, ADDR, LEN payload bytes, CHK) from a valid/ready byte stream, writes
// each payload byte into SPM through the external write port, and releases
// the core from reset only once the frame checksum verifies.
module spm_program_loader #(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,    // asynchronous, active low
  spm_program_loader_if.slave  bus
);

  localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t state_q, state_d;

  // frame parsing registers
  logic [WORD_SIZE-1:0] sum_q, sum_d;
  logic [WORD_SIZE-1:0] remaining_q, remaining_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;

  // registered outputs
  logic                 ext_write_q, ext_write_d;
  logic [WORD_SIZE-1:0] address_bus_q, address_bus_d;
  logic [WORD_SIZE-1:0] data_bus_q, data_bus_d;
  logic                 cpu_rst_n_q, cpu_rst_n_d;
  logic                 err_q, err_d;

  // combinational outputs and helpers
  logic                 in_frame;
  logic                 in_ready_c;
  logic                 busy_c;
  logic                 accept;
  logic [WORD_SIZE-1:0] chk_total;
  logic                 frame_good;

  // The checksum byte makes the frame good when it cancels the running sum.
  assign chk_total  = sum_q + bus.in_data;
  assign frame_good = (chk_total == '0);
  assign accept     = bus.in_valid && in_ready_c;

  // State register; reset returns to S_LEN at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; reload overrides everything, including a valid byte.
  always_comb begin
    state_d = state_q;
    if (bus.reload) begin
      state_d = S_LEN;
    end else if (accept) begin
      case (state_q)
        S_LEN:   state_d = S_ADDR;
        S_ADDR:  state_d = (remaining_q != '0) ? S_DATA : S_CHK;
        S_DATA:  state_d = (remaining_q == ONE) ? S_CHK : S_DATA;
        S_CHK:   state_d = frame_good ? S_RUN : S_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  // Output decode: ready only while a frame is being parsed and no reload.
  always_comb begin
    in_frame   = 1'b0;
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    case (state_q)
      S_LEN, S_ADDR, S_DATA, S_CHK: in_frame = 1'b1;
      default:                      in_frame = 1'b0;
    endcase
    busy_c     = in_frame;
    in_ready_c = in_frame && !bus.reload;
  end

  // Datapath next-state: running sum, byte counter, write address and outputs.
  always_comb begin
    sum_d         = sum_q;
    remaining_d   = remaining_q;
    addr_d        = addr_q;
    ext_write_d   = 1'b0;
    address_bus_d = address_bus_q;
    data_bus_d    = data_bus_q;
    cpu_rst_n_d   = cpu_rst_n_q;
    err_d         = err_q;

    if (bus.reload) begin
      // Entering S_LEN starts a fresh checksum; err is kept until a good frame.
      sum_d       = '0;
      cpu_rst_n_d = 1'b0;
    end else if (accept) begin
      case (state_q)
        S_LEN: begin
          remaining_d = bus.in_data;
          sum_d       = bus.in_data;
        end
        S_ADDR: begin
          addr_d = bus.in_data;
          sum_d  = sum_q + bus.in_data;
        end
        S_DATA: begin
          ext_write_d   = 1'b1;
          address_bus_d = addr_q;
          data_bus_d    = bus.in_data;
          addr_d        = addr_q + ONE;
          sum_d         = sum_q + bus.in_data;
          remaining_d   = remaining_q - ONE;
        end
        S_CHK: begin
          if (frame_good) begin
            cpu_rst_n_d = 1'b1;
            err_d       = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath registers; reset drops any pending write and holds the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q         <= '0;
      remaining_q   <= '0;
      addr_q        <= '0;
      ext_write_q   <= 1'b0;
      address_bus_q <= '0;
      data_bus_q    <= '0;
      cpu_rst_n_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      sum_q         <= sum_d;
      remaining_q   <= remaining_d;
      addr_q        <= addr_d;
      ext_write_q   <= ext_write_d;
      address_bus_q <= address_bus_d;
      data_bus_q    <= data_bus_d;
      cpu_rst_n_q   <= cpu_rst_n_d;
      err_q         <= err_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.busy        = busy_c;
  assign bus.ext_write   = ext_write_q;
  assign bus.address_bus = address_bus_q;
  assign bus.data_bus    = data_bus_q;
  assign bus.cpu_rst_n   = cpu_rst_n_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_spm_program_loader.sv
// Bench for spm_program_loader: table of frames with expected status,
// hand-written reload/reset sequences, and random frames with random
// in_valid gaps, all checked against a memory-image/write-order scoreboard.
module tb_spm_program_loader;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spm_program_loader_if #(.WORD_SIZE(W)) bus ();

  spm_program_loader #(.WORD_SIZE(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wq[$];          // expected writes, in order
  int         n_writes = 0;
  logic [7:0] model_mem [256];
  logic [7:0] dut_mem   [256];
  logic [7:0] pl        [256];
  wr_t        got;

  typedef struct packed {
    logic [7:0]  len;
    logic [7:0]  addr;
    logic [31:0] p;        // first four payload bytes, MSB first
    logic [7:0]  seed;     // byte i >= 4 is seed + i
    logic [7:0]  chk_adj;  // added to the correct checksum
    logic        exp_err;
  } vec_t;

  vec_t vt [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write monitor: every ext_write pulse must match the next expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.ext_write === 1'b1) begin
      n_writes++;
      dut_mem[bus.address_bus] = bus.data_bus;
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%02h:%02h required=none", bus.address_bus, bus.data_bus);
      end else begin
        got = wq.pop_front();
        if (got.a !== bus.address_bus || got.d !== bus.data_bus) begin
          errors++;
          $display("FAIL write_order actual=%02h:%02h required=%02h:%02h",
                   bus.address_bus, bus.data_bus, got.a, got.d);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int  guard;
    int  gaps;
    logic ok;
    guard = 0;
    gaps  = 0;
    if (rnd) begin
      while ($urandom_range(1, 0) == 0 && gaps < 4) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        gaps++;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    forever begin
      #1;
      ok = bus.in_ready;
      @(negedge clk);
      if (ok === 1'b1) break;
      guard++;
      if (guard > 20) begin
        check("accept_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Streams one frame whose payload is in pl[] and checks the final status.
  task automatic run_frame(input logic [7:0] len, input logic [7:0] addr, input logic [7:0] chk,
                           input bit rnd, input logic exp_err, input int id);
    int         w0;
    logic [7:0] a;
    w0 = n_writes;
    send_byte(len, rnd);
    send_byte(addr, rnd);
    for (int i = 0; i < int'(len); i++) begin
      a = addr + 8'(i);
      wq.push_back({a, pl[i]});
      model_mem[a] = pl[i];
      send_byte(pl[i], rnd);
    end
    check("held_before_chk", 32'(bus.cpu_rst_n), 32'd0);
    send_byte(chk, rnd);
    check("cpu_rst_n_after_chk", 32'(bus.cpu_rst_n), 32'(!exp_err));
    check("err_after_chk", 32'(bus.err), 32'(exp_err));
    check("busy_after_chk", 32'(bus.busy), 32'd0);
    check("in_ready_after_chk", 32'(bus.in_ready), 32'd0);
    check("write_count", 32'(n_writes - w0), 32'(len));
    $display("frame %0d len=%0d addr=%02h chk=%02h err=%0b cpu_rst_n=%0b writes=%0d",
             id, len, addr, chk, bus.err, bus.cpu_rst_n, n_writes - w0);
  endtask

  // One-cycle reload from S_RUN/S_ERR back to S_LEN; err must be unchanged.
  task automatic do_reload(input logic prev_err);
    bus.reload = 1'b1;
    #1;
    check("in_ready_during_reload", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.reload = 1'b0;
    #1;
    check("busy_after_reload", 32'(bus.busy), 32'd1);
    check("in_ready_after_reload", 32'(bus.in_ready), 32'd1);
    check("cpu_rst_n_after_reload", 32'(bus.cpu_rst_n), 32'd0);
    check("err_kept_on_reload", 32'(bus.err), 32'(prev_err));
  endtask

  function automatic logic [7:0] frame_sum(input logic [7:0] len, input logic [7:0] addr);
    int s;
    s = int'(len) + int'(addr);
    for (int i = 0; i < int'(len); i++) s += int'(pl[i]);
    return 8'(s);
  endfunction

  initial begin
    logic [7:0] s8;
    logic [7:0] chk;
    logic [7:0] len;
    logic [7:0] addr;
    logic       exp_err;
    int         mism;

    // frame table: the correct checksum is computed from the bytes, chk_adj corrupts it
    vt[0] = '{8'h03, 8'h10, 32'hAABBCC00, 8'h00, 8'h00, 1'b0};
    vt[1] = '{8'h03, 8'h10, 32'hAABBCC00, 8'h00, 8'h01, 1'b1};
    vt[2] = '{8'h03, 8'h10, 32'hAABBCC00, 8'h00, 8'h00, 1'b0};
    vt[3] = '{8'h00, 8'h20, 32'h00000000, 8'h00, 8'h00, 1'b0};
    vt[4] = '{8'h02, 8'hFF, 32'h11220000, 8'h00, 8'h00, 1'b0};
    vt[5] = '{8'h00, 8'h55, 32'h00000000, 8'h00, 8'h03, 1'b1};
    vt[6] = '{8'h05, 8'hF0, 32'h01020304, 8'h40, 8'h80, 1'b1};
    vt[7] = '{8'hFF, 8'h80, 32'hDEADBEEF, 8'h05, 8'h00, 1'b0};
    vt[8] = '{8'h01, 8'h00, 32'h7E000000, 8'h00, 8'h00, 1'b0};

    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'h00;
      dut_mem[i]   = 8'h00;
    end

    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.reload   = 1'b0;
    rst          = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ext_write", 32'(bus.ext_write), 32'd0);
    check("rst_address_bus", 32'(bus.address_bus), 32'd0);
    check("rst_data_bus", 32'(bus.data_bus), 32'd0);
    check("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);

    // table-driven frames, back-to-back bytes
    for (int r = 0; r < 9; r++) begin
      len  = vt[r].len;
      addr = vt[r].addr;
      for (int i = 0; i < int'(len); i++)
        pl[i] = (i < 4) ? vt[r].p[31 - 8*i -: 8] : vt[r].seed + 8'(i);
      s8  = frame_sum(len, addr);
      chk = 8'h00 - s8 + vt[r].chk_adj;
      run_frame(len, addr, chk, 1'b0, vt[r].exp_err, r);
      do_reload(vt[r].exp_err);
    end

    // reload together with a valid payload byte in the middle of a frame
    send_byte(8'h08, 1'b0);
    send_byte(8'h40, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wq.push_back({8'h40 + 8'(i), 8'hC0 + 8'(i)});
      model_mem[8'h40 + 8'(i)] = 8'hC0 + 8'(i);
      send_byte(8'hC0 + 8'(i), 1'b0);
    end
    bus.reload   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.reload   = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd1);
    check("abort_in_ready_after", 32'(bus.in_ready), 32'd1);
    check("abort_no_write", 32'(bus.ext_write), 32'd0);
    check("abort_err_kept", 32'(bus.err), 32'd0);
    @(negedge clk);
    // a fresh good frame only verifies if the running sum was cleared
    pl[0] = 8'h12;
    pl[1] = 8'h34;
    run_frame(8'h02, 8'h50, 8'h00 - frame_sum(8'h02, 8'h50), 1'b0, 1'b0, 100);
    do_reload(1'b0);
    run_frame(8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 101);
    do_reload(1'b1);

    // asynchronous reset while a payload write is pending
    send_byte(8'h04, 1'b0);
    send_byte(8'h60, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    @(posedge clk);
    #1;
    check("pending_write", 32'(bus.ext_write), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_ext_write", 32'(bus.ext_write), 32'd0);
    check("midrst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    check("midrst_address_bus", 32'(bus.address_bus), 32'd0);
    check("midrst_data_bus", 32'(bus.data_bus), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 16-byte frame with randomly gapped in_valid, then random frames
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
    run_frame(8'd16, 8'hA8, 8'h00 - frame_sum(8'd16, 8'hA8), 1'b1, 1'b0, 200);
    do_reload(1'b0);
    exp_err = 1'b0;
    for (int f = 0; f < 20; f++) begin
      len  = 8'($urandom_range(24, 0));
      addr = 8'($urandom);
      for (int i = 0; i < int'(len); i++) pl[i] = 8'($urandom);
      s8 = frame_sum(len, addr);
      if ($urandom_range(3, 0) == 0) chk = 8'($urandom);
      else chk = 8'h00 - s8;
      exp_err = ((int'(s8) + int'(chk)) % 256) != 0;
      run_frame(len, addr, chk, 1'b1, exp_err, 300 + f);
      do_reload(exp_err);
    end

    @(negedge clk);
    check("writes_outstanding", 32'(wq.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < 256; i++)
      if (dut_mem[i] !== model_mem[i]) mism++;
    check("memory_image", 32'(mism), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
